// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM states, AXI response codes and default widths for mem_read_arbiter
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 32;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [2:0] {ARB, ACCEPT, ADDR, DATA, RESP} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin pick.
//   req     - request lines of requesters 0 and 1
//   last    - index of the requester served most recently
//   grant   - index of the winner (meaningful only when any_req)
//   any_req - at least one request is present
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       any_req
);
  // On contention the requester that was not served last wins; otherwise the lone requester.
  assign grant = (&req) ? ~last : req[1];
  assign any_req = |req;
endmodule

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: shares one AXI4-Lite read port between two requesters, one transaction at a time.
//   clk, rstn                                   - clock, async active-low reset
//   s_araddr/s_arvalid/s_arready                - per-requester read address channel
//   s_rdata/s_rresp (shared), s_rvalid/s_rready - per-requester read data channel
//   m_araddr/m_arvalid/m_arready                - memory read address channel
//   m_rdata/m_rresp/m_rvalid/m_rready           - memory read data channel
//   busy                                        - a transaction is in progress
module mem_read_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [2*ADDR_W-1:0] s_araddr,
  input  logic [1:0]          s_arvalid,
  output logic [1:0]          s_arready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic [1:0]          s_rvalid,
  input  logic [1:0]          s_rready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic                busy
);
  state_t state_q, state_d;
  logic g_q, last_q, grant, any_req;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0] rresp_q, g_oh;
  rr_arb2 u_arb (
    .req(s_arvalid),
    .last(last_q),
    .grant(grant),
    .any_req(any_req)
  );
  assign g_oh = g_q ? 2'b10 : 2'b01;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ARB;
    else state_q <= state_d;
  end
  // Outputs depend only on registered state and data, never on inputs directly.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     state_d = any_req ? ACCEPT : ARB;
      ACCEPT:  state_d = ADDR;
      ADDR:    state_d = m_arready ? DATA : ADDR;
      DATA:    state_d = m_rvalid ? RESP : DATA;
      RESP:    state_d = s_rready[g_q] ? ARB : RESP;
      default: state_d = ARB;
    endcase
    s_arready = (state_q == ACCEPT) ? g_oh : 2'b00;
    s_rvalid = (state_q == RESP) ? g_oh : 2'b00;
    m_arvalid = state_q == ADDR;
    m_rready = state_q == DATA;
    busy = state_q != ARB;
    m_araddr = addr_q;
    s_rdata = rdata_q;
    s_rresp = rresp_q;
  end
  // last_q resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      g_q <= 1'b0;
      last_q <= 1'b1;
      addr_q <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      if (state_q == ARB && any_req) begin
        g_q <= grant;
        addr_q <= grant ? s_araddr[2*ADDR_W-1:ADDR_W] : s_araddr[ADDR_W-1:0];
      end
      if (state_q == DATA && m_rvalid) begin
        rdata_q <= m_rdata;
        rresp_q <= m_rresp;
      end
      if (state_q == RESP && s_rready[g_q]) last_q <= g_q;
    end
  end
endmodule

// File: doc/mem_read_arbiter.md
MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 Parameter ADDR_W, default 13, byte-address width of requesters and memory port.
REQ-002 Parameter DATA_W, default 32, read-data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 s_araddr  input  2*ADDR_W  requester addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
REQ-006 s_arvalid  input  2  per-requester address valid.
REQ-007 s_arready  output  2  per-requester address accept.
REQ-008 s_rdata  output  DATA_W  read data, shared by both requesters.
REQ-009 s_rresp  output  2  read response, shared.
REQ-010 s_rvalid  output  2  per-requester data valid.
REQ-011 s_rready  input  2  per-requester data accept.
REQ-012 m_araddr  output  ADDR_W  address to the AXI4-Lite memory slave.
REQ-013 m_arvalid  output  1  memory address valid.
REQ-014 m_arready  input  1  memory address accept.
REQ-015 m_rdata  input  DATA_W  memory read data.
REQ-016 m_rresp  input  2  memory read response.
REQ-017 m_rvalid  input  1  memory data valid.
REQ-018 m_rready  output  1  memory data accept.
REQ-019 busy  output  1  high whenever FSM is not in ARB.

Function
REQ-020 FSM states ARB, ACCEPT, ADDR, DATA, RESP; exactly one transaction outstanding at a time.
REQ-021 ARB: no s_arvalid -> stay; else latch grant index g and s_araddr slice g into addr_q, go ACCEPT.
REQ-022 Arbitration round-robin: single valid requester wins; both valid -> requester not equal to last_q wins.
REQ-023 ACCEPT: s_arready[g]=1 for exactly one cycle, then ADDR.
REQ-024 ADDR: m_arvalid=1, m_araddr=addr_q held stable until m_arready sampled high, then DATA.
REQ-025 DATA: m_rready=1; on m_rvalid latch m_rdata/m_rresp into s_rdata/s_rresp, go RESP.
REQ-026 RESP: s_rvalid[g]=1, s_rdata/s_rresp stable until s_rready[g] sampled high; then last_q<=g, go ARB.
REQ-027 s_rresp forwarded unmodified (SLVERR from memory passes through).
REQ-028 s_arready/s_rvalid of non-granted requester stay 0 throughout a transaction.
REQ-029 Minimum latency: s_arvalid in cycle 0 -> s_arready cycle 1 -> m_arvalid cycle 2 -> s_rvalid cycle 4 with zero-wait memory.
REQ-030 Requester arvalid deasserting while in ARB before grant: no transaction issued.
REQ-031 m_rvalid outside DATA is ignored; m_arready outside ADDR is ignored.
REQ-032 All outputs decoded from registered state/data; no combinational input-to-output path.

Reset
REQ-033 rstn low: FSM to ARB, last_q=1 (requester 0 first priority), addr_q=0, s_rdata=0, s_rresp=0.
REQ-034 During reset all outputs 0; reset mid-transaction discards it with no response to either side.

Structure
REQ-035 Package mem_arb_pkg holds state enum, RESP_OKAY=2'b00, RESP_SLVERR=2'b10, default ADDR_W/DATA_W.
REQ-036 One sub-module rr_arb2: inputs req[1:0], last; output grant index and any_req; purely combinational.

Verification
REQ-037 Req0 only, addr 0x010, memory returns 0xDEADBEEF zero-wait -> m_araddr=0x010, s_rvalid=2'b01 in cycle 4, s_rdata=0xDEADBEEF.
REQ-038 Both requesters valid from reset, addrs 0x004/0x008 -> req0 served first, req1 second, grants alternate on 4 back-to-back pairs.
REQ-039 m_arready delayed 3 cycles, s_rready delayed 5 -> m_araddr and s_rdata held stable; single s_arready pulse.
REQ-040 Memory returns rresp=2'b10 -> s_rresp=2'b10 to granted requester only.
REQ-041 rstn low while in DATA -> all outputs 0 asynchronously; after release req0 transaction completes normally.
